layer_window_feeder: RTL and testbench
======================================

Name: layer_window_feeder

Overview:
- Source end of the parallel A0x..A4x interface consumed by layer node blocks.
- Accepts a serial stream of signed 8-bit ECG samples over a valid/ready handshake.
- Maintains a 5-tap sliding window and presents it in parallel to every node of the layer, with a strobe.
- Produces a result-valid strobe delayed to match the node pipeline, so the downstream collector knows when the N outputs are meaningful.

Parameters:
- DATA_W, 8: sample and tap width (signed two's complement).
- STRIDE, 1: accepted samples between consecutive windows once the window is full; legal range 1..5.
- NODE_LAT, 3: node latency in cycles from A change to N update (input register, sum register, output register).
- CNT_W, 16: width of the window counter.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- s_data, input, DATA_W: incoming sample.
- s_valid, input, 1: s_data valid.
- s_ready, output, 1: feeder accepts s_data this cycle.
- s_last, input, 1: accompanies the final sample of an ECG segment.
- c_ready, input, 1: downstream collector can take a new result.
- A0x, output, DATA_W: oldest tap of the window.
- A1x, output, DATA_W: tap 1.
- A2x, output, DATA_W: tap 2.
- A3x, output, DATA_W: tap 3.
- A4x, output, DATA_W: newest tap of the window.
- win_valid, output, 1: one-cycle pulse; A0x..A4x hold a new window.
- win_last, output, 1: qualifies win_valid; window ends a segment.
- res_valid, output, 1: win_valid delayed NODE_LAT cycles; node N outputs are valid.
- res_last, output, 1: win_last delayed NODE_LAT cycles.
- win_count, output, CNT_W: windows emitted since reset; wraps at 2^CNT_W.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - A0x..A4x = 0, win_valid = 0, win_last = 0, res_valid = 0, res_last = 0, win_count = 0, s_ready = 0.
  - Fill and stride counters = 0; state = FILL; delay line cleared.
  - Reset mid-operation discards pending res_valid pulses and any partial window.
- Handshake:
  - s_ready = c_ready while out of reset; combinational from c_ready only, never from s_valid.
  - A sample is accepted when s_valid && s_ready.
- Shift:
  - On accept, taps shift one place: A0x←A1x, A1x←A2x, A2x←A3x, A3x←A4x, A4x←s_data.
  - The A ports are the shift register itself and are stable between accepts.
- State FILL:
  - fill_cnt counts accepts 0..4.
  - On the 5th accept, go to RUN and emit a window: win_valid = 1 in the next cycle; stride_cnt = 0.
- State RUN:
  - Each accept increments stride_cnt.
  - When stride_cnt reaches STRIDE-1 on an accept, emit a window and clear stride_cnt; otherwise increment it.
  - With STRIDE = 1, every accept emits a window.
- Latency:
  - Sample accepted in cycle t → A ports updated and win_valid high in cycle t+1.
  - res_valid high in cycle t+1+NODE_LAT.
  - win_valid and res_valid are single-cycle pulses, never held.
- s_last:
  - If the accepted sample also completes a window, that window is emitted with win_last = 1.
  - In all cases, state returns to FILL with fill_cnt = 0 and stride_cnt = 0. Taps are not cleared; the next segment overwrites them.
  - s_last during FILL with fewer than 5 samples emits no window; the partial segment is dropped.
- win_count:
  - Increments in the same cycle win_valid asserts.
  - Wraps from 0xFFFF to 0 without saturation.
- Stall: with c_ready low, no accepts; taps, counters and state hold. The delay line keeps shifting, so results already in flight still emerge.
- Delay line: NODE_LAT-deep shift of {win_valid, win_last}. NODE_LAT = 0 is not supported.

Decomposition:
- Shared package (nn_pkg): DATA_W, TAPS = 5, state enum {FILL, RUN}, and the default NODE_LAT constant shared with the node generator.
- Sub-module valid_delay_line (parameter DEPTH, WIDTH = 2): async active-low reset, cleared to 0. It is instantiated once for {win_valid, win_last}.

Test Plan:
- Reset then stream 1,2,3,4,5 (c_ready = 1, STRIDE = 1) → first win_valid one cycle after 5 is accepted with A0x..A4x = 1,2,3,4,5; res_valid exactly 3 cycles later; win_count = 1.
- Continue with 6,7 → two further windows {2,3,4,5,6} and {3,4,5,6,7}; win_count = 3; one res_valid per window.
- STRIDE = 2, stream 10..18 → windows {10..14}, {12..16}, {14..18} only; no pulse on samples 15 and 17.
- s_last on the 5th sample of a segment (values -1,-2,-3,-4,-5) → window with win_last = 1 (A0x = 0xFF, A4x = 0xFB); res_last 3 cycles later; the next 4 samples produce no window.
- s_last on the 3rd sample, then 5 new samples 20..24 → no window for the short segment; next window is {20..24}.
- c_ready low for 4 cycles mid-stream with s_valid held high → s_ready = 0, A ports and win_count frozen, an in-flight res_valid still appears. Assert reset during a pending res_valid → all outputs 0 immediately, and the pending pulse is never produced.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and types for the layer feeder and the node blocks it drives.
// The default node latency lives here so the node generator and feeder agree.
package nn_pkg;

  localparam int NN_DATA_W   = 8;
  localparam int NN_TAPS     = 5;
  localparam int NN_NODE_LAT = 3;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } feed_state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift of a few strobe bits, used to align the window strobe with
// the node pipeline so the collector sees results exactly when N outputs settle.
module valid_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/layer_window_feeder.sv
// Turns a serial sample stream into a 5-tap sliding window presented in parallel
// to every node of a layer, with window and delayed result strobes.
module layer_window_feeder
  import nn_pkg::*;
#(
  parameter int DATA_W   = NN_DATA_W,
  parameter int STRIDE   = 1,
  parameter int NODE_LAT = NN_NODE_LAT,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_last,
  input  logic                     c_ready,
  output logic signed [DATA_W-1:0] A0x,
  output logic signed [DATA_W-1:0] A1x,
  output logic signed [DATA_W-1:0] A2x,
  output logic signed [DATA_W-1:0] A3x,
  output logic signed [DATA_W-1:0] A4x,
  output logic                     win_valid,
  output logic                     win_last,
  output logic                     res_valid,
  output logic                     res_last,
  output logic [CNT_W-1:0]         win_count
);

  localparam logic [2:0] FILL_LAST   = 3'(NN_TAPS - 1);
  localparam logic [2:0] STRIDE_LAST = 3'(STRIDE - 1);

  feed_state_t state;
  feed_state_t state_next;
  logic [2:0]  fill_cnt;
  logic [2:0]  fill_next;
  logic [2:0]  stride_cnt;
  logic [2:0]  stride_next;
  logic        emit;
  logic        accept;
  logic [1:0]  res_bits;

  // Backpressure comes only from the collector; the feeder never stalls on its own.
  assign s_ready = c_ready & reset;
  assign accept  = s_valid & s_ready;

  // Next-count decisions, applied only when a sample is actually accepted.
  always_comb begin
    emit        = 1'b0;
    state_next  = state;
    fill_next   = fill_cnt;
    stride_next = stride_cnt;
    if (state == FILL) begin
      if (fill_cnt == FILL_LAST) begin
        emit        = 1'b1;
        state_next  = RUN;
        fill_next   = '0;
        stride_next = '0;
      end else begin
        fill_next = fill_cnt + 3'd1;
      end
    end else begin
      if (stride_cnt == STRIDE_LAST) begin
        emit        = 1'b1;
        stride_next = '0;
      end else begin
        stride_next = stride_cnt + 3'd1;
      end
    end
    // A segment end always restarts filling; the old taps are simply overwritten.
    if (s_last) begin
      state_next  = FILL;
      fill_next   = '0;
      stride_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      fill_cnt   <= '0;
      stride_cnt <= '0;
      A0x        <= '0;
      A1x        <= '0;
      A2x        <= '0;
      A3x        <= '0;
      A4x        <= '0;
      win_valid  <= 1'b0;
      win_last   <= 1'b0;
      win_count  <= '0;
    end else begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      if (accept) begin
        A0x        <= A1x;
        A1x        <= A2x;
        A2x        <= A3x;
        A3x        <= A4x;
        A4x        <= s_data;
        state      <= state_next;
        fill_cnt   <= fill_next;
        stride_cnt <= stride_next;
        win_valid  <= emit;
        win_last   <= emit & s_last;
        if (emit) win_count <= win_count + CNT_W'(1);
      end
    end
  end

  valid_delay_line #(
    .DEPTH (NODE_LAT),
    .WIDTH (2)
  ) u_res_delay (
    .clk   (clk),
    .reset (reset),
    .din   ({win_valid, win_last}),
    .dout  (res_bits)
  );

  assign res_valid = res_bits[1];
  assign res_last  = res_bits[0];

endmodule

// File: tb/tb_layer_window_feeder.sv
// Directed scoreboard bench: two feeders (STRIDE 1 and 2) driven one at a time,
// expected windows and results queued at accept time and popped on strobes.
module tb_layer_window_feeder;

  typedef struct {
    logic [4:0][7:0] t;
    logic            last;
    logic [15:0]     cnt;
    longint          at;
  } wexp_t;

  typedef struct {
    logic   last;
    longint at;
  } rexp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sv, sl, cr;
  logic [7:0] sd [2];
  logic [1:0] sready, wv, wl, rv, rl;
  logic [7:0] tp [2][5];
  logic [15:0] wc [2];

  int     ncomp = 0;
  int     nfail = 0;
  longint cyc = 0;

  wexp_t wq0[$], wq1[$];
  rexp_t rq0[$], rq1[$];

  int         mfill [2];
  int         mstride [2];
  int         mrun [2];
  int         mcnt [2];
  logic [7:0] mt [2][5];
  int         strd [2] = '{1, 2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer_window_feeder #(.STRIDE(1)) dut0 (
    .clk(clk), .reset(reset), .s_data(sd[0]), .s_valid(sv[0]), .s_ready(sready[0]),
    .s_last(sl[0]), .c_ready(cr[0]), .A0x(tp[0][0]), .A1x(tp[0][1]), .A2x(tp[0][2]),
    .A3x(tp[0][3]), .A4x(tp[0][4]), .win_valid(wv[0]), .win_last(wl[0]),
    .res_valid(rv[0]), .res_last(rl[0]), .win_count(wc[0])
  );

  layer_window_feeder #(.STRIDE(2)) dut1 (
    .clk(clk), .reset(reset), .s_data(sd[1]), .s_valid(sv[1]), .s_ready(sready[1]),
    .s_last(sl[1]), .c_ready(cr[1]), .A0x(tp[1][0]), .A1x(tp[1][1]), .A2x(tp[1][2]),
    .A3x(tp[1][3]), .A4x(tp[1][4]), .win_valid(wv[1]), .win_last(wl[1]),
    .res_valid(rv[1]), .res_last(rl[1]), .win_count(wc[1])
  );

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mfill[d] = 0; mstride[d] = 0; mrun[d] = 0; mcnt[d] = 0;
      for (int i = 0; i < 5; i++) mt[d][i] = 8'h00;
    end
    wq0.delete(); wq1.delete(); rq0.delete(); rq1.delete();
  endtask

  task automatic model_accept(input int d, input logic [7:0] data, input logic last);
    bit    emit = 0;
    wexp_t e;
    rexp_t r;
    for (int i = 0; i < 4; i++) mt[d][i] = mt[d][i+1];
    mt[d][4] = data;
    if (mrun[d] == 0) begin
      if (mfill[d] == 4) begin emit = 1; mrun[d] = 1; mstride[d] = 0; end
      else mfill[d]++;
    end else begin
      if (mstride[d] == strd[d] - 1) begin emit = 1; mstride[d] = 0; end
      else mstride[d]++;
    end
    if (last) begin mrun[d] = 0; mfill[d] = 0; mstride[d] = 0; end
    if (emit) begin
      mcnt[d] = (mcnt[d] + 1) & 16'hFFFF;
      for (int i = 0; i < 5; i++) e.t[i] = mt[d][i];
      e.last = last;
      e.cnt  = 16'(mcnt[d]);
      e.at   = cyc + 1;
      r.last = last;
      r.at   = cyc + 4;
      if (d == 0) begin wq0.push_back(e); rq0.push_back(r); end
      else        begin wq1.push_back(e); rq1.push_back(r); end
    end
  endtask

  // One directed step: drive at negedge, so exactly one posedge sees these inputs.
  task automatic step(input int d, input logic [7:0] data, input logic v, input logic last, input logic crdy);
    @(negedge clk);
    sd[d] = data; sv[d] = v; sl[d] = last; cr[d] = crdy;
    #1;
    check("s_ready", d, 32'(sready[d]), 32'(crdy));
    if (v && crdy) model_accept(d, data, last);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sv = 2'b00; sl = 2'b00; cr = 2'b11;
    end
  endtask

  task automatic mon(input int d);
    wexp_t e;
    rexp_t r;
    int    nw, nr;
    nw = (d == 0) ? wq0.size() : wq1.size();
    nr = (d == 0) ? rq0.size() : rq1.size();
    if (wv[d]) begin
      if (nw == 0) check("win_unexpected", d, 32'd1, 32'd0);
      else begin
        e = (d == 0) ? wq0.pop_front() : wq1.pop_front();
        check("win_time", d, 32'(cyc), 32'(e.at));
        for (int i = 0; i < 5; i++) check("win_tap", d, 32'(tp[d][i]), 32'(e.t[i]));
        check("win_last", d, 32'(wl[d]), 32'(e.last));
        check("win_count", d, 32'(wc[d]), 32'(e.cnt));
      end
    end else if (nw > 0) begin
      e = (d == 0) ? wq0[0] : wq1[0];
      if (e.at <= cyc) begin
        if (d == 0) void'(wq0.pop_front()); else void'(wq1.pop_front());
        check("win_missing", d, 32'd0, 32'd1);
      end
    end
    if (rv[d]) begin
      if (nr == 0) check("res_unexpected", d, 32'd1, 32'd0);
      else begin
        r = (d == 0) ? rq0.pop_front() : rq1.pop_front();
        check("res_time", d, 32'(cyc), 32'(r.at));
        check("res_last", d, 32'(rl[d]), 32'(r.last));
      end
    end else if (nr > 0) begin
      r = (d == 0) ? rq0[0] : rq1[0];
      if (r.at <= cyc) begin
        if (d == 0) void'(rq0.pop_front()); else void'(rq1.pop_front());
        check("res_missing", d, 32'd0, 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    reset = 1'b0;
    sv = 2'b00; sl = 2'b00; cr = 2'b11;
    sd[0] = 8'h00; sd[1] = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_a0", d, 32'(tp[d][0]), 32'd0);
      check("rst_a4", d, 32'(tp[d][4]), 32'd0);
      check("rst_win_valid", d, 32'(wv[d]), 32'd0);
      check("rst_res_valid", d, 32'(rv[d]), 32'd0);
      check("rst_win_count", d, 32'(wc[d]), 32'd0);
      check("rst_s_ready", d, 32'(sready[d]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    // First window and two stride-1 follow-ups.
    for (int v = 1; v <= 5; v++) step(0, 8'(v), 1'b1, 1'b0, 1'b1);
    idle(5);
    check("t1_count", 0, 32'(wc[0]), 32'd1);
    check("t1_a0", 0, 32'(tp[0][0]), 32'd1);
    check("t1_a4", 0, 32'(tp[0][4]), 32'd5);
    step(0, 8'd6, 1'b1, 1'b0, 1'b1);
    step(0, 8'd7, 1'b1, 1'b0, 1'b1);
    idle(5);
    check("t2_count", 0, 32'(wc[0]), 32'd3);
    check("t2_a0", 0, 32'(tp[0][0]), 32'd3);

    // Stride 2 on the second instance.
    for (int v = 10; v <= 18; v++) step(1, 8'(v), 1'b1, 1'b0, 1'b1);
    idle(5);
    check("t3_count", 1, 32'(wc[1]), 32'd3);
    check("t3_a0", 1, 32'(tp[1][0]), 32'd14);

    // Close the running segment, then a full segment ending on its 5th sample.
    step(0, 8'd8, 1'b1, 1'b1, 1'b1);
    idle(5);
    check("t4_count", 0, 32'(wc[0]), 32'd4);
    for (int v = 1; v <= 5; v++) step(0, 8'(-v), 1'b1, (v == 5), 1'b1);
    idle(5);
    check("t4_a0", 0, 32'(tp[0][0]), 32'hFF);
    check("t4_a4", 0, 32'(tp[0][4]), 32'hFB);
    check("t4_count2", 0, 32'(wc[0]), 32'd5);

    // Short segments produce nothing; the next full segment starts clean.
    for (int v = 40; v <= 43; v++) step(0, 8'(v), 1'b1, (v == 43), 1'b1);
    for (int v = 50; v <= 52; v++) step(0, 8'(v), 1'b1, (v == 52), 1'b1);
    idle(3);
    check("t5_count", 0, 32'(wc[0]), 32'd5);
    for (int v = 20; v <= 24; v++) step(0, 8'(v), 1'b1, 1'b0, 1'b1);
    idle(5);
    check("t5_a0", 0, 32'(tp[0][0]), 32'd20);
    check("t5_a4", 0, 32'(tp[0][4]), 32'd24);
    check("t5_count2", 0, 32'(wc[0]), 32'd6);

    // Stall with a result in flight.
    step(0, 8'd25, 1'b1, 1'b0, 1'b1);
    repeat (4) step(0, 8'd99, 1'b1, 1'b0, 1'b0);
    check("t6_a0", 0, 32'(tp[0][0]), 32'd21);
    check("t6_a4", 0, 32'(tp[0][4]), 32'd25);
    check("t6_count", 0, 32'(wc[0]), 32'd7);
    idle(3);

    // Reset while a result is pending: it must never appear.
    step(0, 8'd26, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    sv = 2'b00; sl = 2'b00;
    model_reset();
    #1;
    check("t7_a0", 0, 32'(tp[0][0]), 32'd0);
    check("t7_a4", 0, 32'(tp[0][4]), 32'd0);
    check("t7_win_valid", 0, 32'(wv[0]), 32'd0);
    check("t7_res_valid", 0, 32'(rv[0]), 32'd0);
    check("t7_count", 0, 32'(wc[0]), 32'd0);
    check("t7_s_ready", 0, 32'(sready[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(8);

    check("drain_win0", 0, 32'(wq0.size()), 32'd0);
    check("drain_res0", 0, 32'(rq0.size()), 32'd0);
    check("drain_win1", 1, 32'(wq1.size()), 32'd0);
    check("drain_res1", 1, 32'(rq1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
